seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the seven-segment display path.
- Owns refresh timing, digit sequencing, anti-ghosting dead time, per-digit enable/blanking and tear-free value updates.
- Drives the anode select and the nibble fed to the segment decoder. Sits between the value-producing logic and the segment decoder.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (>=2).
- DIGIT_W, 4: bits per digit value.
- PRESCALE, 50000: clk cycles per digit slot (> GHOST_CYCLES).
- GHOST_CYCLES, 16: dead-time cycles at the start of each slot with all anodes off (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- load_valid  in  1  new display word offered.
- load_ready  out  1  controller can accept a word.
- load_data  in  NUM_DIGITS*DIGIT_W  digit i at bits [i*DIGIT_W +: DIGIT_W].
- digit_en  in  NUM_DIGITS  per-digit enable mask.
- blank  in  1  force all anodes off.
- an  out  NUM_DIGITS  anode selects, active-low.
- led_output  out  DIGIT_W  value for the active slot's digit.
- digit_idx  out  IDX_W=clog2(NUM_DIGITS)  current slot index.
- frame_done  out  1  one-cycle end-of-frame strobe.

Behaviour:
- Reset (async assert): an=all ones, led_output=0, digit_idx=0, frame_done=0, load_ready=1, display and shadow registers=0, pending=0, state=ST_GHOST, counter=0. Slot 0 starts the first cycle after rst deasserts.
- Slot timing:
  - Each slot lasts exactly PRESCALE cycles.
  - ST_GHOST covers cycles 0..GHOST_CYCLES-1 of the slot; an=all ones.
  - ST_ON covers cycles GHOST_CYCLES..PRESCALE-1; an[digit_idx]=0 when digit_en[digit_idx]=1 and blank=0, otherwise all ones.
  - All outputs are registered.
- Sequencing:
  - The slot-end edge advances digit_idx by 1 and returns to ST_GHOST.
  - digit_idx wraps from NUM_DIGITS-1 to 0.
  - Disabled digits still occupy their slot, so the frame period stays constant at NUM_DIGITS*PRESCALE.
- led_output equals display digit [digit_idx] for the whole slot, including ghost time.
- frame_done is high during the last cycle of slot NUM_DIGITS-1 only.
- blank and digit_en take effect on an from the next cycle. Counters are unaffected.
- Load handshake:
  - load_ready = !pending.
  - Transfer on a cycle where load_valid && load_ready: shadow<=load_data, pending<=1.
  - The frame-end edge commits a pending shadow to the display register and clears pending. The display never changes mid-frame.
  - Simultaneous commit and new transfer on the same edge: the commit uses the old shadow; the new word is captured and stays pending until the next frame end.
  - load_data is ignored when no transfer occurs.
- Reset mid-slot or mid-frame: immediate return to reset values; a pending word is discarded.

Optional Feature:
- Macro SEG_SCAN_BRIGHTNESS_EN.
- When defined:
  - Adds input port brightness [2:0].
  - With L=PRESCALE-GHOST_CYCLES, an is driven low only for the first ((brightness+1)*L)>>3 cycles of ST_ON; the rest of the slot is all ones.
  - brightness is sampled at slot start and held for the slot.
- When undefined: no port; full ST_ON window.

Decomposition:
- Package seg_scan_pkg holds:
  - state enum {ST_GHOST, ST_ON};
  - IDX_W/clog2 helper;
  - default constants for PRESCALE and GHOST_CYCLES.
- Sub-module seg_slot_timer: prescale counter producing phase (ghost/on), on-cycle count and slot_end strobe.
- The top level keeps index, shadow/pending handshake and output registers.

Test Plan (NUM_DIGITS=2, DIGIT_W=4, PRESCALE=8, GHOST_CYCLES=2, digit_en=2'b11, blank=0):
- Reset release, load 8'hA5 at cycle 1 -> load_ready=0 at cycle 2. First frame shows 0/0. From cycle 16: slot 0 has led_output=5, an=2'b11 for 2 cycles then 2'b10 for 6; slot 1 has led_output=A, an=2'b01 for 6 cycles.
- Second load_valid held while pending -> not accepted; load_ready rises after frame-end edge; next word displays one frame later.
- digit_en=2'b10 -> an[0] never low; an[1] low exactly 6 of every 16 cycles; frame period unchanged.
- rst pulsed during slot 1 ST_ON with word pending -> an=2'b11 immediately, digit_idx=0, load_ready=1, old value not committed.
- Free run 64 cycles -> frame_done high exactly 4 times, 16 cycles apart, each 1 cycle wide, coinciding with digit_idx=1.
- SEG_SCAN_BRIGHTNESS_EN, brightness=3 -> L=6, an low 3 cycles per enabled slot; brightness=7 -> 6 cycles.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// The optional brightness feature is enabled with SEG_SCAN_BRIGHTNESS_EN.
package seg_scan_pkg;
  typedef enum logic {ST_GHOST = 1'b0, ST_ON = 1'b1} state_e;

  localparam int DEF_PRESCALE     = 50000;
  localparam int DEF_GHOST_CYCLES = 16;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seg_slot_timer.sv
// Per-slot prescale counter: ghost/on phase, slot-end strobe and look-ahead
// values used to register the top-level outputs. SEG_SCAN_BRIGHTNESS_EN adds on-count.
module seg_slot_timer
  import seg_scan_pkg::*;
#(
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int GHOST_CYCLES = DEF_GHOST_CYCLES,
  parameter int CNT_W        = $clog2(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             o_slot_end,
  output logic             o_last_nxt,
  output state_e           o_phase_nxt
`ifdef SEG_SCAN_BRIGHTNESS_EN
  ,
  output logic             o_first,
  output logic [CNT_W-1:0] o_on_cnt_nxt
`endif
);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GLAST = CNT_W'(GHOST_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  state_e           r_phase;

  assign o_slot_end  = (r_cnt == LAST);
  assign w_cnt_nxt   = o_slot_end ? '0 : r_cnt + CNT_W'(1);
  assign o_last_nxt  = (w_cnt_nxt == LAST);
  // Ghost always ends before the slot does, so the two branches never collide.
  assign o_phase_nxt = o_slot_end ? ST_GHOST : ((r_cnt == GLAST) ? ST_ON : r_phase);

`ifdef SEG_SCAN_BRIGHTNESS_EN
  assign o_first      = (r_cnt == '0);
  assign o_on_cnt_nxt = w_cnt_nxt - CNT_W'(GHOST_CYCLES);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= ST_GHOST;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_phase <= o_phase_nxt;
    end
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with tear-free frame updates.
// Define SEG_SCAN_BRIGHTNESS_EN to add the 3-bit brightness (on-window) input.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_W      = 4,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int GHOST_CYCLES = DEF_GHOST_CYCLES,
  parameter int IDX_W        = idx_w(NUM_DIGITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          blank,
`ifdef SEG_SCAN_BRIGHTNESS_EN
  input  logic [2:0]                    brightness,
`endif
  output logic [NUM_DIGITS-1:0]         an,
  output logic [DIGIT_W-1:0]            led_output,
  output logic [IDX_W-1:0]              digit_idx,
  output logic                          frame_done
);
  localparam int               DW       = NUM_DIGITS * DIGIT_W;
  localparam int               CNT_W    = $clog2(PRESCALE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0] r_an;
  logic [DIGIT_W-1:0]    r_led;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_frame_done;
  logic                  r_ready;
  logic                  r_pending;
  logic [DW-1:0]         r_shadow;
  logic [DW-1:0]         r_disp;

  logic                  w_slot_end;
  logic                  w_last_nxt;
  state_e                w_phase_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  w_commit;
  logic                  w_xfer;
  logic                  w_pending_nxt;
  logic [DW-1:0]         w_disp_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [DIGIT_W-1:0]    w_led_nxt;
  logic                  w_on;

`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic             w_first;
  logic [CNT_W-1:0] w_on_cnt_nxt;
  logic [2:0]       r_bright;
  logic [2:0]       w_bright;
  logic [CNT_W+3:0] w_win;
`endif

  seg_slot_timer #(
    .PRESCALE    (PRESCALE),
    .GHOST_CYCLES(GHOST_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .o_slot_end  (w_slot_end),
    .o_last_nxt  (w_last_nxt),
    .o_phase_nxt (w_phase_nxt)
`ifdef SEG_SCAN_BRIGHTNESS_EN
    ,
    .o_first     (w_first),
    .o_on_cnt_nxt(w_on_cnt_nxt)
`endif
  );

  assign w_commit      = w_slot_end && (r_idx == LAST_IDX);
  assign w_xfer        = load_valid && r_ready;
  assign w_idx_nxt     = w_slot_end ? ((r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1)) : r_idx;
  // Commit reads the old shadow; a word captured on the same edge waits a frame.
  assign w_pending_nxt = w_xfer ? 1'b1 : (w_commit ? 1'b0 : r_pending);
  assign w_disp_nxt    = (w_commit && r_pending) ? r_shadow : r_disp;

`ifdef SEG_SCAN_BRIGHTNESS_EN
  // Brightness is latched on the first cycle of each slot, inside ghost time.
  assign w_bright = w_first ? brightness : r_bright;
  assign w_win    = (({{(CNT_W+1){1'b0}}, w_bright} + (CNT_W+4)'(1))
                     * (CNT_W+4)'(PRESCALE - GHOST_CYCLES)) >> 3;
  assign w_on     = (w_phase_nxt == ST_ON) && digit_en[w_idx_nxt] && !blank
                    && ({4'b0, w_on_cnt_nxt} < w_win);
`else
  assign w_on     = (w_phase_nxt == ST_ON) && digit_en[w_idx_nxt] && !blank;
`endif

  always_comb begin
    w_an_nxt = '1;
    if (w_on) w_an_nxt[w_idx_nxt] = 1'b0;
  end

  always_comb begin
    w_led_nxt = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (IDX_W'(i) == w_idx_nxt) w_led_nxt = w_disp_nxt[i*DIGIT_W +: DIGIT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an         <= '1;
      r_led        <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
      r_ready      <= 1'b1;
      r_pending    <= 1'b0;
      r_shadow     <= '0;
      r_disp       <= '0;
    end else begin
      r_an         <= w_an_nxt;
      r_led        <= w_led_nxt;
      r_idx        <= w_idx_nxt;
      r_frame_done <= w_last_nxt && (w_idx_nxt == LAST_IDX);
      r_ready      <= !w_pending_nxt;
      r_pending    <= w_pending_nxt;
      r_disp       <= w_disp_nxt;
      if (w_xfer) r_shadow <= load_data;
    end
  end

`ifdef SEG_SCAN_BRIGHTNESS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bright <= 3'd7;
    else     r_bright <= w_bright;
  end
`endif

  assign an         = r_an;
  assign led_output = r_led;
  assign digit_idx  = r_idx;
  assign frame_done = r_frame_done;
  assign load_ready = r_ready;
endmodule
